q2_phase_scan: RTL and testbench

Q2_PHASE_SCAN -- requirements
Module: q2_phase_scan

---
 rtl/q2_phase_scan_if.sv | 35 +++
 rtl/q2_phase_scan.sv | 102 ++++++++++
 tb/tb_q2_phase_scan.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/q2_phase_scan_if.sv
// Q2 scan bus: start/busy/done handshake, Q2 row-0 literals and the per-vector results.
// The abort line exists only when Q2_SCAN_ABORT_EN is defined.
interface q2_phase_scan_if #(
   parameter int num_qubit  = 4,
   parameter int max_vector = 2**num_qubit
);
   logic                                  start;
   logic [num_qubit-1:0][1:0]             literals_Q2_row0;
   logic                                  phase_Q2_row0;
   logic [max_vector-1:0][num_qubit-1:0]  basis_index2;
   logic                                  rotateLeft_Q2_individual;
   logic                                  busy;
   logic                                  done;
   logic [max_vector-1:0][1:0]            amp_exp;
   logic [max_vector-1:0][num_qubit-1:0]  basis_out;
`ifdef Q2_SCAN_ABORT_EN
   logic                                  abort;
`endif

   modport master (
`ifdef Q2_SCAN_ABORT_EN
      output abort,
`endif
      output start, literals_Q2_row0, phase_Q2_row0, basis_index2,
      input  rotateLeft_Q2_individual, busy, done, amp_exp, basis_out
   );

   modport slave (
`ifdef Q2_SCAN_ABORT_EN
      input  abort,
`endif
      input  start, literals_Q2_row0, phase_Q2_row0, basis_index2,
      output rotateLeft_Q2_individual, busy, done, amp_exp, basis_out
   );
endinterface

// File: rtl/q2_phase_scan.sv
// Walks every Q2 vector through row 0 by rotating Q2 storage, recording amplitude exponent and flipped basis.
// Optional feature macro: Q2_SCAN_ABORT_EN adds an abort input that cancels a scan in progress.
module q2_phase_scan #(
   parameter int num_qubit  = 4,
   parameter int max_vector = 2**num_qubit
) (
   input  logic           clk,
   input  logic           rst,
   q2_phase_scan_if.slave bus
);
   localparam int CW = (max_vector > 1) ? $clog2(max_vector) : 1;
   localparam logic [CW-1:0] LAST = CW'(max_vector - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t                                state_q, state_d;
   logic [CW-1:0]                         cnt_q;
   logic [max_vector-1:0][1:0]            amp_q;
   logic [max_vector-1:0][num_qubit-1:0]  bout_q;
   logic                                  rotate, busy, done;

   // i^k exponent: sign contributes 2, each Y contributes 1 (Y = iXZ), each Z hitting a set basis bit contributes 2
   function automatic logic [1:0] amp_fn(
      input logic [num_qubit-1:0][1:0] lit,
      input logic                      ph,
      input logic [num_qubit-1:0]      basis
   );
      logic [1:0] acc;
      acc = {ph, 1'b0};
      for (int j = 0; j < num_qubit; j++) begin
         if (lit[j] == 2'b11)
            acc = acc + 2'd1;
         if (lit[j][0] && basis[j])
            acc = acc + 2'd2;
      end
      return acc;
   endfunction

   function automatic logic [num_qubit-1:0] xflip_fn(
      input logic [num_qubit-1:0][1:0] lit,
      input logic [num_qubit-1:0]      basis
   );
      logic [num_qubit-1:0] r;
      for (int j = 0; j < num_qubit; j++)
         r[j] = basis[j] ^ lit[j][1];
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      rotate  = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start)
               state_d = SCAN;
         end
         SCAN: begin
            busy   = 1'b1;
            rotate = 1'b1;
`ifdef Q2_SCAN_ABORT_EN
            if (bus.abort) begin
               rotate  = 1'b0;
               state_d = IDLE;
            end else
`endif
            if (cnt_q == LAST)
               state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Results are written only on cycles that also rotate, so an aborted cycle leaves its slot untouched
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         amp_q   <= '0;
         bout_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == SCAN)
            cnt_q <= (state_d == SCAN) ? cnt_q + CW'(1) : '0;
         if (rotate) begin
            amp_q[cnt_q]  <= amp_fn(bus.literals_Q2_row0, bus.phase_Q2_row0, bus.basis_index2[cnt_q]);
            bout_q[cnt_q] <= xflip_fn(bus.literals_Q2_row0, bus.basis_index2[cnt_q]);
         end
      end
   end

   assign bus.rotateLeft_Q2_individual = rotate;
   assign bus.busy                     = busy;
   assign bus.done                     = done;
   assign bus.amp_exp                  = amp_q;
   assign bus.basis_out                = bout_q;
endmodule

// File: tb/tb_q2_phase_scan.sv
// Self-checking bench for q2_phase_scan (num_qubit=2, max_vector=4) with a rotating Q2 storage model.
// Abort scenario is compiled only with Q2_SCAN_ABORT_EN.
module tb_q2_phase_scan;
   localparam int NQ = 2;
   localparam int MV = 4;

   typedef struct {
      int         slot;
      logic [1:0] amp;
      logic [1:0] bout;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;
   exp_t sbq[$];

   logic [1:0][1:0] lit_tab [MV];
   logic            ph_tab  [MV];
   logic [1:0]      ofs = 2'd0;

   q2_phase_scan_if #(.num_qubit(NQ), .max_vector(MV)) intf ();

   q2_phase_scan #(.num_qubit(NQ), .max_vector(MV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (intf)
   );

   always #5 clk = ~clk;

   // Q2 storage: row 0 is the vector at offset ofs; each rotate command advances by one vector
   always @(posedge clk)
      if (intf.rotateLeft_Q2_individual === 1'b1)
         ofs <= ofs + 2'd1;

   assign intf.literals_Q2_row0 = lit_tab[ofs];
   assign intf.phase_Q2_row0    = ph_tab[ofs];

   function automatic logic [1:0] ref_amp(input logic [1:0][1:0] lit, input logic ph, input logic [1:0] b);
      int s;
      s = ph ? 2 : 0;
      for (int q = 0; q < NQ; q++) begin
         if (lit[q] == 2'b11) s += 1;
         if (lit[q][0] && b[q]) s += 2;
      end
      return 2'(s % 4);
   endfunction

   function automatic logic [1:0] ref_bout(input logic [1:0][1:0] lit, input logic [1:0] b);
      return b ^ {lit[1][1], lit[0][1]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one start, follows the scan for a fixed window, pushes expectations per rotating cycle
   task automatic run_scan(input int again_at, input int abort_at,
                           output int rots, output int dones, output int done_at, output int bad_done);
      logic [1:0] base;
      int         k;
      rots = 0; dones = 0; done_at = -1; bad_done = 0;
      base = ofs;
      intf.start = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         intf.start = (c == again_at);
`ifdef Q2_SCAN_ABORT_EN
         intf.abort = (c == abort_at);
`else
         if (abort_at > 0 && c == abort_at) intf.start = intf.start;
`endif
         #1;
         if (intf.rotateLeft_Q2_individual === 1'b1) begin
            k = (int'(base) + rots) % MV;
            sbq.push_back('{rots, ref_amp(lit_tab[k], ph_tab[k], intf.basis_index2[rots]),
                                  ref_bout(lit_tab[k], intf.basis_index2[rots])});
            rots++;
         end
         if (intf.done === 1'b1) begin
            dones++;
            done_at = c;
            if (intf.busy !== 1'b0 || intf.rotateLeft_Q2_individual !== 1'b0) bad_done++;
         end
      end
      intf.start = 1'b0;
`ifdef Q2_SCAN_ABORT_EN
      intf.abort = 1'b0;
`endif
   endtask

   task automatic check_sb(input string tag);
      exp_t e;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         total++;
         if (intf.amp_exp[e.slot] !== e.amp) begin
            bad++;
            $display("FAIL %s amp_exp[%0d] got=%0d want=%0d", tag, e.slot, intf.amp_exp[e.slot], e.amp);
         end
         total++;
         if (intf.basis_out[e.slot] !== e.bout) begin
            bad++;
            $display("FAIL %s basis_out[%0d] got=%b want=%b", tag, e.slot, intf.basis_out[e.slot], e.bout);
         end
      end
   endtask

   task automatic test_reset();
      #2;
      total++;
      if (intf.busy !== 1'b0 || intf.done !== 1'b0 || intf.rotateLeft_Q2_individual !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctrl got busy=%b done=%b rot=%b want 0/0/0", intf.busy, intf.done,
                  intf.rotateLeft_Q2_individual);
      end
      total++;
      if (intf.amp_exp !== '0 || intf.basis_out !== '0) begin
         bad++;
         $display("FAIL reset_data got amp=%h bout=%h want 0/0", intf.amp_exp, intf.basis_out);
      end
      tick();
      tick();
      rst = 1'b1;
      tick();
      total++;
      if (intf.busy !== 1'b0 || intf.done !== 1'b0) begin
         bad++;
         $display("FAIL reset_release got busy=%b done=%b want 0/0", intf.busy, intf.done);
      end
   endtask

   task automatic test_scan();
      int rots, dones, done_at, bad_done;
      logic [1:0] base;
      logic [MV-1:0][1:0] amp_keep;
      logic [MV-1:0][1:0] bout_keep;
      lit_tab[0] = {2'b10, 2'b01}; ph_tab[0] = 1'b0;  // XZ,+
      lit_tab[1] = {2'b11, 2'b00}; ph_tab[1] = 1'b1;  // YI,-
      lit_tab[2] = {2'b00, 2'b00}; ph_tab[2] = 1'b0;  // II,+
      lit_tab[3] = {2'b01, 2'b01}; ph_tab[3] = 1'b1;  // ZZ,-
      intf.basis_index2 = {2'b11, 2'b10, 2'b01, 2'b00};
      base = ofs;
      for (int i = 0; i < MV; i++) begin
         amp_keep[i]  = ref_amp(lit_tab[(int'(base) + i) % MV], ph_tab[(int'(base) + i) % MV], intf.basis_index2[i]);
         bout_keep[i] = ref_bout(lit_tab[(int'(base) + i) % MV], intf.basis_index2[i]);
      end
      run_scan(0, 0, rots, dones, done_at, bad_done);
      total++;
      if (rots !== 4) begin bad++; $display("FAIL scan_rotates got=%0d want=4", rots); end
      total++;
      if (dones !== 1 || done_at !== 5) begin
         bad++; $display("FAIL scan_done got count=%0d cycle=%0d want 1 at 5", dones, done_at);
      end
      total++;
      if (bad_done !== 0) begin bad++; $display("FAIL scan_done_quiet got=%0d want=0", bad_done); end
      total++;
      if (ofs !== base) begin bad++; $display("FAIL scan_q2_order got ofs=%0d want=%0d", ofs, base); end
      check_sb("scan");
      intf.basis_index2 = {2'b01, 2'b11, 2'b00, 2'b10};
      lit_tab[0] = {2'b11, 2'b11};
      tick(); tick(); tick();
      total++;
      if (intf.amp_exp !== amp_keep || intf.basis_out !== bout_keep) begin
         bad++;
         $display("FAIL hold_idle got amp=%h bout=%h want amp=%h bout=%h", intf.amp_exp, intf.basis_out,
                  amp_keep, bout_keep);
      end
   endtask

   task automatic test_start_during_scan();
      int rots, dones, done_at, bad_done;
      for (int i = 0; i < MV; i++) begin
         lit_tab[i] = 4'($urandom_range(0, 15));
         ph_tab[i]  = 1'($urandom_range(0, 1));
      end
      intf.basis_index2 = 8'($urandom_range(0, 255));
      run_scan(2, 0, rots, dones, done_at, bad_done);
      total++;
      if (rots !== 4 || dones !== 1 || done_at !== 5) begin
         bad++;
         $display("FAIL restart_ignored got rot=%0d done=%0d at %0d want 4/1 at 5", rots, dones, done_at);
      end
      check_sb("restart");
   endtask

   task automatic test_yy();
      int rots, dones, done_at, bad_done;
      for (int i = 0; i < MV; i++) begin
         lit_tab[i] = {2'b11, 2'b11};
         ph_tab[i]  = 1'b1;
      end
      intf.basis_index2 = '1;
      run_scan(0, 0, rots, dones, done_at, bad_done);
      total++;
      if (intf.amp_exp !== '0) begin
         bad++; $display("FAIL yy_amp got=%h want=0", intf.amp_exp);
      end
      total++;
      if (intf.basis_out !== '0) begin
         bad++; $display("FAIL yy_bout got=%h want=0", intf.basis_out);
      end
      check_sb("yy");
   endtask

   task automatic test_reset_mid();
      int dones;
      dones = 0;
      lit_tab[0] = {2'b10, 2'b10}; ph_tab[0] = 1'b1;
      lit_tab[1] = {2'b10, 2'b10}; ph_tab[1] = 1'b1;
      lit_tab[2] = {2'b10, 2'b10}; ph_tab[2] = 1'b1;
      lit_tab[3] = {2'b10, 2'b10}; ph_tab[3] = 1'b1;
      intf.basis_index2 = '0;
      intf.start = 1'b1;
      tick();
      intf.start = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      total++;
      if (intf.busy !== 1'b0 || intf.rotateLeft_Q2_individual !== 1'b0 || intf.done !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid_ctrl got busy=%b rot=%b done=%b want 0", intf.busy,
                  intf.rotateLeft_Q2_individual, intf.done);
      end
      tick();
      total++;
      if (intf.amp_exp !== '0 || intf.basis_out !== '0) begin
         bad++; $display("FAIL rst_mid_data got amp=%h bout=%h want 0", intf.amp_exp, intf.basis_out);
      end
      rst = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (intf.done === 1'b1 || intf.busy === 1'b1) dones++;
      end
      total++;
      if (dones !== 0) begin bad++; $display("FAIL rst_mid_no_done got=%0d want=0", dones); end
   endtask

`ifdef Q2_SCAN_ABORT_EN
   task automatic test_abort();
      int rots, dones, done_at, bad_done;
      lit_tab[0] = {2'b11, 2'b00}; ph_tab[0] = 1'b1;
      lit_tab[1] = {2'b10, 2'b11}; ph_tab[1] = 1'b0;
      lit_tab[2] = {2'b01, 2'b10}; ph_tab[2] = 1'b1;
      lit_tab[3] = {2'b11, 2'b11}; ph_tab[3] = 1'b0;
      intf.basis_index2 = {2'b10, 2'b01, 2'b11, 2'b01};
      run_scan(0, 3, rots, dones, done_at, bad_done);
      total++;
      if (rots !== 2 || dones !== 0) begin
         bad++; $display("FAIL abort_flow got rot=%0d done=%0d want 2/0", rots, dones);
      end
      total++;
      if (intf.busy !== 1'b0) begin bad++; $display("FAIL abort_idle got busy=%b want 0", intf.busy); end
      check_sb("abort");
   endtask
`endif

   initial begin
      intf.start = 1'b0;
      intf.basis_index2 = '0;
`ifdef Q2_SCAN_ABORT_EN
      intf.abort = 1'b0;
`endif
      for (int i = 0; i < MV; i++) begin
         lit_tab[i] = '0;
         ph_tab[i]  = 1'b0;
      end
      test_reset();
      test_scan();
      test_start_during_scan();
      test_yy();
      test_reset_mid();
`ifdef Q2_SCAN_ABORT_EN
      test_abort();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
